// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: opcodes, FSM states,
// ALU/write-back select encodings and the decoded-instruction payload.
package mc_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_RTYPE = 2'b01;
    localparam logic [1:0] ALU_ITYPE = 2'b10;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;

    typedef struct packed {
        logic       valid;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       op_a_sel;
        logic       op_b_sel;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class flags plus the ALU
// operand/op selects and write-back source for the current IR opcode.
module mc_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output dec_t       dec
);

    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.op_b_sel = 1'b1;
        dec.alu_op   = ALU_ADD;
        dec.wb_sel   = WB_ALU;
        case (opcode)
            OPC_LOAD: begin
                dec.is_load = 1'b1;
                dec.wb_sel  = WB_MEM;
            end
            OPC_STORE: dec.is_store = 1'b1;
            OPC_OP: begin
                dec.op_b_sel = 1'b0;
                dec.alu_op   = ALU_RTYPE;
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.op_a_sel  = 1'b1;
            end
            OPC_OPIMM: dec.alu_op = ALU_ITYPE;
            OPC_JAL: begin
                dec.is_jump  = 1'b1;
                dec.op_a_sel = 1'b1;
                dec.wb_sel   = WB_PC4;
            end
            OPC_JALR: begin
                dec.is_jump = 1'b1;
                dec.wb_sel  = WB_PC4;
            end
            OPC_LUI:   dec.op_a_sel = 1'b0;
            OPC_AUIPC: dec.op_a_sel = 1'b1;
            default:   dec.valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-style control FSM: fetch/decode/exec/mem/wb sequencing
// over a shared single-port memory, with a memory wait timeout and retire counter.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 branch,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 mem_wren,
    output logic                 mem_addr_sel,
    output logic                 ir_wren,
    output logic                 pc_wren,
    output logic                 rd_wren,
    output logic                 br_sel,
    output logic                 op_a_sel,
    output logic                 op_b_sel,
    output logic [1:0]           alu_op,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [2:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            cur_state;
    state_t            nxt_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_inc;
    logic              timeout;
    dec_t              dec;

    mc_decode u_decode (
        .opcode (opcode),
        .dec    (dec)
    );

    // State, wait counter and retire counter; the counter clears whenever the FSM moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            wait_cnt  <= '0;
            instret   <= '0;
        end else begin
            cur_state <= nxt_state;
            wait_cnt  <= wait_inc ? wait_cnt + WAIT_W'(1) : '0;
            if (pc_wren) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

    assign timeout = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign trap    = (cur_state == S_TRAP);
    assign state   = cur_state;

    always_comb begin
        nxt_state    = cur_state;
        wait_inc     = 1'b0;
        mem_req      = 1'b0;
        mem_wren     = 1'b0;
        mem_addr_sel = 1'b0;
        ir_wren      = 1'b0;
        pc_wren      = 1'b0;
        rd_wren      = 1'b0;
        br_sel       = 1'b0;
        op_a_sel     = 1'b0;
        op_b_sel     = 1'b0;
        alu_op       = ALU_ADD;
        wb_sel       = WB_PC4;
        case (cur_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_wren   = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timeout) begin
                    nxt_state = S_TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_DECODE: nxt_state = dec.valid ? S_EXEC : S_TRAP;
            S_EXEC: begin
                op_a_sel = dec.op_a_sel;
                op_b_sel = dec.op_b_sel;
                alu_op   = dec.alu_op;
                if (dec.is_load || dec.is_store) begin
                    nxt_state = S_MEM;
                end else if (dec.is_branch) begin
                    pc_wren   = 1'b1;
                    br_sel    = branch;
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_WB;
                end
            end
            S_MEM: begin
                // Address comes from the ALU, so its operand selects stay put.
                op_a_sel     = dec.op_a_sel;
                op_b_sel     = dec.op_b_sel;
                alu_op       = dec.alu_op;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_wren     = dec.is_store;
                if (mem_ack) begin
                    if (dec.is_store) begin
                        pc_wren   = 1'b1;
                        nxt_state = S_FETCH;
                    end else begin
                        nxt_state = S_WB;
                    end
                end else if (timeout) begin
                    nxt_state = S_TRAP;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            S_WB: begin
                rd_wren   = 1'b1;
                pc_wren   = 1'b1;
                wb_sel    = dec.wb_sel;
                br_sel    = dec.is_jump;
                nxt_state = S_FETCH;
            end
            S_TRAP:  nxt_state = S_TRAP;
            default: nxt_state = S_TRAP;
        endcase
        // Reset silences the memory port and all write enables immediately.
        if (rst) begin
            mem_req  = 1'b0;
            mem_wren = 1'b0;
            ir_wren  = 1'b0;
            pc_wren  = 1'b0;
            rd_wren  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: table of per-instruction-class vectors
// plus hand sequences for reset, illegal opcode, fetch timeout and retire wrap.
module tb_multicycle_ctrl;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       branch;
    logic       mem_ack;
    logic       mem_req, mem_wren, mem_addr_sel, ir_wren, pc_wren, rd_wren;
    logic       br_sel, op_a_sel, op_b_sel, trap;
    logic [1:0] alu_op, wb_sel;
    logic [2:0] state;
    logic [3:0] instret;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_instret = 4'd0;

    multicycle_ctrl #(.MEM_TIMEOUT(15), .INSTRET_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch       (branch),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_wren     (mem_wren),
        .mem_addr_sel (mem_addr_sel),
        .ir_wren      (ir_wren),
        .pc_wren      (pc_wren),
        .rd_wren      (rd_wren),
        .br_sel       (br_sel),
        .op_a_sel     (op_a_sel),
        .op_b_sel     (op_b_sel),
        .alu_op       (alu_op),
        .wb_sel       (wb_sel),
        .trap         (trap),
        .state        (state),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opcode;
        logic        branch;
        int          fd;
        int          md;
        int          cycles;
        logic [23:0] seq;
        int          memc;
        logic        wren;
        int          rdc;
        logic [1:0]  wb;
        logic        br;
        logic        a;
        logic        b;
        logic [1:0]  alu;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic [6:0] opc, input logic br_in, input int fd, input int md,
                                input int cycles, input logic [23:0] seq, input int memc,
                                input logic wren, input int rdc, input logic [1:0] wb,
                                input logic br, input logic a, input logic b, input logic [1:0] alu);
        vec_t v;
        v.opcode = opc; v.branch = br_in; v.fd = fd; v.md = md; v.cycles = cycles; v.seq = seq;
        v.memc = memc; v.wren = wren; v.rdc = rdc; v.wb = wb; v.br = br; v.a = a; v.b = b; v.alu = alu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a negedge with the DUT in FETCH; leaves at the negedge after retirement.
    task automatic run_instr(input vec_t v, input int idx);
        int cyc = 0, fcnt = 0, mcnt = 0, memc = 0, rdc = 0, pcc = 0;
        logic wren_seen = 1'b0, brv = 1'b0, av = 1'b0, bv = 1'b0, done = 1'b0;
        logic [1:0] wbv = 2'b0, aluv = 2'b0;
        logic [23:0] seq = 24'd0;
        logic [2:0] prev = 3'd7;
        opcode = v.opcode;
        branch = v.branch;
        while (!done && cyc < 64) begin
            if (cyc > 0) @(negedge clk);
            mem_ack = (state == 3'd0 && fcnt == v.fd) || (state == 3'd3 && mcnt == v.md);
            #1;
            if (state != prev) seq = {seq[20:0], state};
            prev = state;
            if (state == 3'd3 && mem_req) memc++;
            if (mem_wren) wren_seen = 1'b1;
            if (rd_wren) begin rdc++; wbv = wb_sel; end
            if (pc_wren) begin pcc++; brv = br_sel; done = 1'b1; end
            if (state == 3'd2) begin av = op_a_sel; bv = op_b_sel; aluv = alu_op; end
            if (state == 3'd5) done = 1'b1;
            if (state == 3'd0) fcnt++;
            if (state == 3'd3) mcnt++;
            cyc++;
        end
        if (!done) check($sformatf("v%0d_no_retire", idx), 32'd0, 32'd1);
        check($sformatf("v%0d_cycles", idx), cyc, v.cycles);
        check($sformatf("v%0d_states", idx), seq, v.seq);
        check($sformatf("v%0d_mem_req_cycles", idx), memc, v.memc);
        check($sformatf("v%0d_mem_wren", idx), wren_seen, v.wren);
        check($sformatf("v%0d_rd_wren_count", idx), rdc, v.rdc);
        if (v.rdc > 0) check($sformatf("v%0d_wb_sel", idx), wbv, v.wb);
        check($sformatf("v%0d_pc_wren_count", idx), pcc, 1);
        check($sformatf("v%0d_br_sel", idx), brv, v.br);
        check($sformatf("v%0d_exec_sels", idx), {av, bv, aluv}, {v.a, v.b, v.alu});
        @(negedge clk);
        exp_instret = exp_instret + 4'd1;
        check($sformatf("v%0d_back_to_fetch", idx), state, 3'd0);
        check($sformatf("v%0d_instret", idx), instret, exp_instret);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
            check("rst_enables_quiet", {mem_req, mem_wren, ir_wren, pc_wren, rd_wren}, 5'b0);
        end
        check("rst_state", state, 3'd0);
        check("rst_trap", trap, 1'b0);
        check("rst_instret", instret, 4'd0);
        rst = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("rst_first_mem_req", mem_req, 1'b1);
        exp_instret = 4'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        vec_t add_v;
        rst = 1'b1; opcode = 7'b0; branch = 1'b0; mem_ack = 1'b0;
        //           opcode      br fd  md  cyc seq       memc wren rdc wb     br    a     b     alu
        vecs[0]  = mk(7'b0110011, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        vecs[1]  = mk(7'b0000011, 0, 2,  3, 10, 24'o1234, 4,   0,   1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00);
        vecs[2]  = mk(7'b0100011, 0, 0,  1,  5, 24'o123,  2,   1,   0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
        vecs[3]  = mk(7'b1100011, 1, 1,  0,  4, 24'o12,   0,   0,   0, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00);
        vecs[4]  = mk(7'b1100011, 0, 0,  0,  3, 24'o12,   0,   0,   0, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
        vecs[5]  = mk(7'b0010011, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b01, 1'b0, 1'b0, 1'b1, 2'b10);
        vecs[6]  = mk(7'b1101111, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b00, 1'b1, 1'b1, 1'b1, 2'b00);
        vecs[7]  = mk(7'b1100111, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b00, 1'b1, 1'b0, 1'b1, 2'b00);
        vecs[8]  = mk(7'b0110111, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b01, 1'b0, 1'b0, 1'b1, 2'b00);
        vecs[9]  = mk(7'b0010111, 0, 0,  0,  4, 24'o124,  0,   0,   1, 2'b01, 1'b0, 1'b1, 1'b1, 2'b00);
        vecs[10] = mk(7'b0100011, 0, 0,  0,  4, 24'o123,  1,   1,   0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00);
        vecs[11] = mk(7'b0110011, 0, 14, 0, 18, 24'o124,  0,   0,   1, 2'b01, 1'b0, 1'b0, 1'b0, 2'b01);
        vecs[12] = mk(7'b0000011, 0, 0, 14, 19, 24'o1234, 15,  0,   1, 2'b10, 1'b0, 1'b0, 1'b1, 2'b00);
        add_v = vecs[0];

        do_reset();
        for (int i = 0; i < NVEC; i++) run_instr(vecs[i], i);
        for (int i = 0; i < 3; i++) run_instr(add_v, NVEC + i);
        check("instret_wrapped", instret, 4'd0);
        run_instr(add_v, 99);

        // Reset in the middle of a store's memory phase.
        opcode = 7'b0100011;
        mem_ack = 1'b1;
        @(negedge clk); mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        check("store_mem_state", state, 3'd3);
        check("store_mem_wren", mem_wren, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("store_rst_wren_gated", mem_wren, 1'b0);
        @(negedge clk); #1;
        check("store_rst_state", state, 3'd0);
        check("store_rst_instret", instret, 4'd0);
        check("store_rst_mem_quiet", {mem_req, mem_wren}, 2'b0);
        rst = 1'b0;
        #1;
        check("store_rst_first_req", mem_req, 1'b1);
        exp_instret = 4'd0;

        // Illegal opcode traps after decode and stays trapped.
        opcode = 7'b0000000;
        mem_ack = 1'b1;
        #1;
        check("illegal_ir_wren", ir_wren, 1'b1);
        @(negedge clk); mem_ack = 1'b0; #1;
        check("illegal_decode", state, 3'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("trap_hold_%0d", k),
                  {state, trap, mem_req, mem_wren, ir_wren, pc_wren, rd_wren, instret},
                  {3'd5, 1'b1, 5'b0, exp_instret});
        end

        // Fetch with no ack at all: trap after 15 waiting cycles.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            mem_ack = 1'b0;
            #1;
            if (k == 14) check("fetch_wait_14", state, 3'd0);
            if (k == 15) check("fetch_timeout_trap", {state, trap}, {3'd5, 1'b1});
        end
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
